// File: rtl/ee457_regfile_mr2w.sv
// Multi-read, dual-write register file with a post-reset clear sequencer.
// Optional same-cycle write-to-read forwarding: define EE457_REGFILE_BYPASS_EN.
module ee457_regfile_mr2w #(
  parameter int ADDR_SIZE = 5,
  parameter int DATA_SIZE = 32,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD*ADDR_SIZE-1:0]   ra,
  output logic [NUM_RD*DATA_SIZE-1:0]   rdata,
  input  logic [ADDR_SIZE-1:0]          wa0,
  input  logic [DATA_SIZE-1:0]          wdata0,
  input  logic                          wen0,
  input  logic [ADDR_SIZE-1:0]          wa1,
  input  logic [DATA_SIZE-1:0]          wdata1,
  input  logic                          wen1,
  output logic                          init_busy
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t                 state;
  logic [ADDR_SIZE-1:0]   clr_ptr;
  logic [DATA_SIZE-1:0]   regarray [DEPTH];
  logic                   we0;
  logic                   we1;

  function automatic logic is_zero_reg(input logic [ADDR_SIZE-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 wins an address collision, so port 0 is suppressed outright.
  assign we1 = (state == ST_RUN) && wen1 && !is_zero_reg(wa1);
  assign we0 = (state == ST_RUN) && wen0 && !is_zero_reg(wa0) && !(wen1 && (wa1 == wa0));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      clr_ptr   <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_RESET: state <= ST_CLEAR;
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + ADDR_SIZE'(1);
          if (clr_ptr == LAST_IDX) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_RESET;
      endcase
    end
  end

  // NOTE: the array has no reset term; the clear sequencer zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) regarray[clr_ptr] <= '0;
      if (we0)               regarray[wa0]     <= wdata0;
      if (we1)               regarray[wa1]     <= wdata1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] rd;

    assign addr = ra[i*ADDR_SIZE +: ADDR_SIZE];
    assign rdata[i*DATA_SIZE +: DATA_SIZE] = rd;

    // NOTE: rd gets a default first so no path through this block can infer a latch.
    always_comb begin
      rd = '0;
      if (!init_busy && !is_zero_reg(addr)) begin
`ifdef EE457_REGFILE_BYPASS_EN
        if (we1 && (wa1 == addr))      rd = wdata1;
        else if (we0 && (wa0 == addr)) rd = wdata0;
        else                           rd = regarray[addr];
`else
        rd = regarray[addr];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ee457_regfile_mr2w.sv
// Scoreboard bench for ee457_regfile_mr2w (4 read ports, ZERO_REG = 1).
module tb_ee457_regfile_mr2w;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int DEPTH = 1 << AW;

  logic              clk;
  logic              rst_n;
  logic [NR*AW-1:0]  ra;
  logic [NR*DW-1:0]  rdata;
  logic [AW-1:0]     wa0, wa1;
  logic [DW-1:0]     wdata0, wdata1;
  logic              wen0, wen1;
  logic              init_busy;

  ee457_regfile_mr2w #(
    .ADDR_SIZE(AW), .DATA_SIZE(DW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rdata(rdata),
    .wa0(wa0), .wdata0(wdata0), .wen0(wen0),
    .wa1(wa1), .wdata1(wdata1), .wen1(wen1),
    .init_busy(init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  bit          running;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    if (!running || a == '0) return '0;
`ifdef EE457_REGFILE_BYPASS_EN
    if (wen1 && wa1 == a) return wdata1;
    if (wen0 && wa0 == a) return wdata0;
`endif
    return model[a];
  endfunction

  task automatic set_w(input logic e0, input logic [AW-1:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [AW-1:0] a1, input logic [31:0] d1);
    wen0 = e0; wa0 = a0; wdata0 = d0;
    wen1 = e1; wa1 = a1; wdata1 = d1;
  endtask

  task automatic set_ra(input int a0, input int a1, input int a2, input int a3);
    ra = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask

  // Push expectations for the current inputs, compare at negedge, then clock once.
  task automatic step(input string tag);
    exp_t e;
    for (int p = 0; p < NR; p++) begin
      e.tag  = tag;
      e.port = p;
      e.val  = exp_rd(ra[p*AW +: AW]);
      sb.push_back(e);
    end
    @(negedge clk);
    check({tag, "_busy"}, {31'b0, init_busy}, running ? 32'd0 : 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s_p%0d", e.tag, e.port), rdata[e.port*DW +: DW], e.val);
    end
    @(posedge clk);
    if (running) begin
      if (wen0 && wa0 != '0) model[wa0] = wdata0;
      if (wen1 && wa1 != '0) model[wa1] = wdata1;
    end
    #1;
  endtask

  // Count posedges from release until init_busy drops; bounded.
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (!init_busy) break;
    end
    wen0 = 1'b0;
    check(tag, 32'(k), 32'(DEPTH + 1));
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    running = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    running  = 1'b0;
    rst_n    = 1'b0;
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    set_ra(0, 1, 2, 3);
    @(posedge clk);
    #1;
    step("rst0");
    step("rst1");

    // Release reset; a write attempted during CLEAR must be ignored.
    rst_n = 1'b1;
    set_w(1'b1, 5'd6, 32'hFFFF_FFFF, 1'b0, '0, '0);
    wait_ready("busy_len");
    for (int b = 0; b < DEPTH; b += 4) begin
      set_ra(b, b + 1, b + 2, b + 3);
      step("clr_rd");
    end

    // Basic write and zero-register drop.
    set_w(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'h0000_1234);
    set_ra(5, 0, 5, 0);
    step("wr5");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    step("rd5");
    check("rd5_direct", rdata[0 +: DW], 32'hDEAD_BEEF);
    check("rd0_direct", rdata[DW +: DW], 32'h0);

    // Collision on entry 7, then two distinct addresses in one cycle.
    set_w(1'b1, 5'd7, 32'h0000_1111, 1'b1, 5'd7, 32'h0000_2222);
    set_ra(7, 3, 4, 5);
    step("coll");
    set_w(1'b1, 5'd3, 32'h0000_3333, 1'b1, 5'd4, 32'h0000_4444);
    step("dual");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    step("after");
    check("coll7_direct", rdata[0 +: DW], 32'h0000_2222);
    check("dual3_direct", rdata[DW +: DW], 32'h0000_3333);
    check("dual4_direct", rdata[2*DW +: DW], 32'h0000_4444);

    // Forwarding: old value 0x55 in entry 9, then same-cycle write while reading it.
    set_w(1'b1, 5'd9, 32'h0000_0055, 1'b0, '0, '0);
    set_ra(0, 9, 9, 1);
    step("fwd_pre");
    set_w(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, '0, '0);
    step("fwd_same");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    step("fwd_next");
    check("fwd_next_direct", rdata[DW +: DW], 32'hA5A5_A5A5);

    // Multi-port read of one address.
    set_w(1'b0, '0, '0, 1'b1, 5'd12, 32'h0BAD_F00D);
    set_ra(12, 12, 12, 12);
    step("mp_wr");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    step("mp_rd");
    for (int p = 0; p < NR; p++)
      check($sformatf("mp_direct_p%0d", p), rdata[p*DW +: DW], 32'h0BAD_F00D);

    // Reset in the middle of CLEAR restarts the full sequence.
    set_w(1'b1, 5'd20, 32'hCAFE_0000, 1'b0, '0, '0);
    set_ra(20, 12, 7, 9);
    step("w20");
    set_w(1'b0, '0, '0, 1'b0, '0, '0);
    step("r20");
    rst_n = 1'b0;
    running = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
    end
    check("mid_busy", {31'b0, init_busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", {31'b0, init_busy}, 32'd1);
    rst_n = 1'b1;
    wait_ready("busy_len2");
    step("clr2_rd");
    check("e20_cleared", rdata[0 +: DW], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ee457_regfile_mr2w.md
Name: ee457_regfile_mr2w

Overview:
Parametrised register file for the pipelined CPU. It has NUM_RD combinational read ports and two synchronous write ports with fixed priority. It adds a post-reset hardware clear sequencer, which zeroes one entry per cycle and reports when done. Optional same-cycle write-to-read forwarding removes the need for half-cycle register-file tricks in the ID/WB stages.

Parameters:
ADDR_SIZE, 5, address width; DEPTH = 1 << ADDR_SIZE entries
DATA_SIZE, 32, entry width in bits
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and writes to it are dropped; 0 = entry 0 is an ordinary register

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  synchronous reset, active-low, sampled on posedge clk
ra  in  NUM_RD*ADDR_SIZE  packed read addresses; port i = ra[i*ADDR_SIZE +: ADDR_SIZE]
rdata  out  NUM_RD*DATA_SIZE  packed read data; port i = rdata[i*DATA_SIZE +: DATA_SIZE]
wa0  in  ADDR_SIZE  write port 0 address
wdata0  in  DATA_SIZE  write port 0 data
wen0  in  1  write port 0 enable
wa1  in  ADDR_SIZE  write port 1 address (higher priority)
wdata1  in  DATA_SIZE  write port 1 data
wen1  in  1  write port 1 enable
init_busy  out  1  1 while reset or clear sequence in progress; 0 = ready for writes

Behaviour:
- Clock/reset: one clock (clk); rst_n is synchronous, active-low, sampled on posedge clk.
- States: RESET, CLEAR, RUN.
- rst_n low at posedge:
  - state <= RESET; clear counter clr_ptr <= 0; init_busy <= 1.
  - Array contents are not touched by reset itself.
- RESET -> CLEAR on the first posedge with rst_n high.
- CLEAR:
  - Each posedge writes 0 to regarray[clr_ptr]; clr_ptr <= clr_ptr + 1.
  - When clr_ptr == DEPTH-1 is written, state <= RUN and init_busy <= 0.
  - CLEAR lasts exactly DEPTH cycles.
  - init_busy falls DEPTH+1 posedges after the first posedge sampling rst_n high, counting the RESET->CLEAR edge.
- RUN: normal operation; stays in RUN until rst_n is low.
- Reset mid-CLEAR: returns to RESET and the clear restarts from entry 0. No partial-progress retention.
- Writes:
  - Accepted only in RUN, at posedge, when wenX = 1.
  - wenX is ignored in RESET/CLEAR, with no queuing.
  - ZERO_REG = 1: a write with waX == 0 is dropped.
  - wen0 & wen1 & (wa0 == wa1): port 1's data is stored and port 0's write is discarded.
  - Different addresses: both writes are stored in the same cycle.
- Reads (combinational, per port i):
  - init_busy = 1 -> rdata_i = 0.
  - Else ZERO_REG = 1 and ra_i == 0 -> 0.
  - Else forwarding or array value, per the Optional Feature.
- Multiple read ports may carry the same address; each returns an identical value.
- Read latency is 0 cycles. Write-to-array latency is 1 posedge.
- Out-of-range addresses cannot occur because DEPTH = 2^ADDR_SIZE.

Optional Feature:
Macro: EE457_REGFILE_BYPASS_EN
- Defined:
  - In RUN, a read port whose address matches an enabled, non-dropped write this cycle returns that write's data combinationally.
  - If both write ports match, wdata1 is returned.
  - A dropped write to entry 0 under ZERO_REG = 1 still reads 0.
  - The result is that WB-to-ID same-cycle hazards need no external forwarding.
- Undefined:
  - rdata returns the stored array value, i.e. the pre-write contents.
  - The new value is visible the cycle after the posedge.
- Array update timing is identical in both builds.

Test Plan:
- Clear sequence: hold rst_n = 0 for 2 cycles, then release.
  - init_busy = 1 for exactly DEPTH+1 = 33 posedges after release, then 0.
  - Reading all 32 entries then returns 32'h0.
  - wen0 = 1 asserted during CLEAR has no effect.
- Basic write/read:
  - RUN: write wa0 = 5, wdata0 = 32'hDEADBEEF.
  - Next cycle ra port0 = 5 returns 32'hDEADBEEF.
  - Writing wa1 = 0, wdata1 = 32'h1234 (ZERO_REG = 1) leaves reads of entry 0 at 32'h0.
- Write collision:
  - wen0 = wen1 = 1, wa0 = wa1 = 7, wdata0 = 32'h1111, wdata1 = 32'h2222.
  - Entry 7 reads 32'h2222 afterwards.
  - In the same cycle, wa0 = 3 and wa1 = 4 with distinct data: both entries are updated.
- Forwarding:
  - Same-cycle write wa0 = 9, wdata0 = 32'hA5A5A5A5 while ra port1 = 9.
  - BYPASS_EN build: rdata port1 = 32'hA5A5A5A5 in that cycle.
  - Non-bypass build: the old value in that cycle, 32'hA5A5A5A5 the next cycle.
- Reset mid-clear:
  - Assert rst_n = 0 for 1 cycle after 10 CLEAR cycles.
  - init_busy stays 1; the full 33-cycle sequence restarts.
  - Previously written entries (e.g. entry 20 = 32'hCAFE0000) read 0 after completion.
- Multi-port read (NUM_RD = 4):
  - All four ra set to 12 after writing 32'h0BADF00D.
  - All four rdata lanes equal 32'h0BADF00D.
